fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Forwarding and load-use hazard unit for the pipelined MIPS core. It sits in the ID stage and tracks destination registers of the instructions in EX, MEM and WB in an internal scoreboard. It produces registered 2-bit select codes for the two EX-stage 4:1 operand multiplexers, and a combinational stall that freezes PC and IF/ID and injects a bubble into ID/EX.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `id_valid` in 1: an instruction is present in ID.
- `id_rs`, `id_rt` in 5 each: source register numbers.
- `id_uses_rs`, `id_uses_rt` in 1 each: the instruction actually reads that source.
- `id_dest` in 5: destination register.
- `id_reg_write` in 1: the instruction writes `id_dest`.
- `id_mem_read` in 1: the instruction is a load.
- `flush` in 1: branch/jump redirect; kills the ID instruction.
- `pipe_hold` in 1: global freeze, e.g. memory wait.
- `fwd_a_sel`, `fwd_b_sel` out 2 each: operand-mux selects for the instruction now in EX.
- `stall` out 1: load-use stall request, combinational.

## Operation
- Select encoding:
  - 0 = register-file value from ID/EX.
  - 1 = EX/MEM ALU result.
  - 2 = MEM/WB writeback data.
  - 3 = retired-result register, holding the value written back one cycle earlier.
- Scoreboard entries EX, MEM, WB each hold {valid, reg_write, mem_read, dest}.
- A producer matches source `s` when all of these hold:
  - the entry is valid and has reg_write set;
  - `dest == s` and `dest != 0`;
  - the matching `id_uses_*` is 1.
- Select computation for each operand:
  - Compare EX, then MEM, then WB. The nearest match wins.
  - An EX match gives 1, a MEM match gives 2, a WB match gives 3.
  - No match gives 0.
  - The result is registered into `fwd_*_sel` on the edge that moves the instruction into EX.
- `stall` = `id_valid` & !`flush` & (EX entry is a load that matches rs or rt).
- Scoreboard advance on each edge with `pipe_hold` = 0:
  - WB <= MEM, MEM <= EX.
  - EX <= ID info if `id_valid` & !`stall` & !`flush`; otherwise EX becomes invalid (bubble).
  - When EX receives a bubble, `fwd_*_sel` is set to 0.
- With `pipe_hold` = 1, all state and both `fwd_*_sel` hold. `stall` is still computed.
- Boundary rules:
  - `flush` together with a load-use condition: `flush` wins, `stall` = 0, and a bubble enters EX.
  - A source of r0 always gives select 0.
  - One source matching both EX and MEM gives select 1.
  - rs and rt equal: both selects are identical.
  - Reset mid-operation: all entries are invalidated immediately and the outputs return to their reset values.

## Timing
- Reset values: `fwd_a_sel` = 0, `fwd_b_sel` = 0, `stall` = 0, all scoreboard entries invalid.
- `fwd_*_sel` are valid for the whole EX cycle of their instruction, with latency 1 from ID.
- Load-use stall lasts exactly 1 cycle, not counting hold cycles. In the next cycle the load sits in MEM and the consumer receives select 2.
- `stall` depends only on ID inputs and registered state. There is no path from `fwd_*_sel` to `stall`.

## Configuration
- `FWD_RETIRE_BYPASS_EN` defined:
  - A WB-entry match gives select 3.
  - The retired-result path in EX is used.
- `FWD_RETIRE_BYPASS_EN` undefined:
  - The WB entry is not compared and select 3 is never produced.
  - The register file is required to be write-through.
  - The WB scoreboard entry is not instantiated.

## Structure
- Shared package `mips_pipe_pkg`:
  - select constants `FWD_SEL_RF`, `FWD_SEL_EXMEM`, `FWD_SEL_MEMWB`, `FWD_SEL_RETIRE`;
  - the scoreboard entry struct type;
  - the register-number width constant.
- One sub-module `fwd_sel_compare`, instantiated twice (operands A and B). It takes one source plus the three entries and returns the prioritized select.

## Test plan
- `add r3` followed immediately by `add` reading r3 as rs -> `fwd_a_sel` = 1 in the consumer's EX cycle; `fwd_b_sel` = 0.
- `lw r5` followed immediately by a reader of r5 as rt -> `stall` = 1 for one cycle, one bubble (both sels 0), then `fwd_b_sel` = 2.
- Producer of r7 three instructions ahead of its reader -> `fwd_a_sel` = 3 with `FWD_RETIRE_BYPASS_EN`, 0 without it.
- Writes to r4 at distances 1 and 2, then a read of r4 -> select 1. Any producer writing r0 -> select 0.
- Load-use condition with `flush` = 1 in the same cycle -> `stall` = 0 and a bubble enters EX. Load-use condition with `pipe_hold` = 1 for 3 cycles -> `stall` is held and the selects are unchanged.
- `rst_n` asserted mid-stream with a pending load-use -> `stall` and both sels go to 0 immediately, and the first instruction after reset gets select 0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the MIPS core: operand-forwarding select codes,
// the hazard scoreboard entry type and the producer/source match helper.
package mips_pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_SEL_RF     = 2'd0;
  localparam logic [1:0] FWD_SEL_EXMEM  = 2'd1;
  localparam logic [1:0] FWD_SEL_MEMWB  = 2'd2;
  localparam logic [1:0] FWD_SEL_RETIRE = 2'd3;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic [REG_W-1:0] dest;
  } sb_entry_t;

  // r0 is hardwired to zero, so it never counts as a produced value.
  // load_only narrows the match to loads for the load-use check.
  function automatic logic entry_match(input sb_entry_t e, input logic [REG_W-1:0] src,
                                       input logic uses_src, input logic load_only);
    return e.valid && e.reg_write && uses_src && (e.dest == src) &&
           (e.dest != '0) && (!load_only || e.mem_read);
  endfunction

endpackage

// File: rtl/fwd_sel_compare.sv
// Prioritized forwarding select for one operand: nearest producer (EX, MEM, WB) wins.
// The WB comparison exists only when FWD_RETIRE_BYPASS_EN is defined.
module fwd_sel_compare
  import mips_pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             uses_src,
  input  sb_entry_t        ex_entry,
  input  sb_entry_t        mem_entry,
`ifdef FWD_RETIRE_BYPASS_EN
  input  sb_entry_t        wb_entry,
`endif
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_SEL_RF;
    if (entry_match(ex_entry, src, uses_src, 1'b0))
      sel = FWD_SEL_EXMEM;
    else if (entry_match(mem_entry, src, uses_src, 1'b0))
      sel = FWD_SEL_MEMWB;
`ifdef FWD_RETIRE_BYPASS_EN
    else if (entry_match(wb_entry, src, uses_src, 1'b0))
      sel = FWD_SEL_RETIRE;
`endif
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding and load-use hazard unit with an EX/MEM/WB destination scoreboard.
// Define FWD_RETIRE_BYPASS_EN to track the WB entry and produce the retired-result select.
module fwd_hazard_unit
  import mips_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  input  logic             pipe_hold,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall
);

  sb_entry_t  ex_q;
  sb_entry_t  mem_q;
`ifdef FWD_RETIRE_BYPASS_EN
  sb_entry_t  wb_q;
`endif
  sb_entry_t  id_entry;
  logic       issue;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // Only a load sitting in EX can cause a stall; its data is not ready until MEM.
  always_comb begin
    stall = id_valid && !flush &&
            (entry_match(ex_q, id_rs, id_uses_rs, 1'b1) ||
             entry_match(ex_q, id_rt, id_uses_rt, 1'b1));
    issue = id_valid && !stall && !flush;
    id_entry = '{valid: 1'b1, reg_write: id_reg_write, mem_read: id_mem_read, dest: id_dest};
  end

  fwd_sel_compare u_cmp_a (
    .src       (id_rs),
    .uses_src  (id_uses_rs),
    .ex_entry  (ex_q),
    .mem_entry (mem_q),
`ifdef FWD_RETIRE_BYPASS_EN
    .wb_entry  (wb_q),
`endif
    .sel       (sel_a)
  );

  fwd_sel_compare u_cmp_b (
    .src       (id_rt),
    .uses_src  (id_uses_rt),
    .ex_entry  (ex_q),
    .mem_entry (mem_q),
`ifdef FWD_RETIRE_BYPASS_EN
    .wb_entry  (wb_q),
`endif
    .sel       (sel_b)
  );

  // Selects travel with the instruction into EX; a bubble always reads the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
`ifdef FWD_RETIRE_BYPASS_EN
      wb_q      <= '0;
`endif
      fwd_a_sel <= FWD_SEL_RF;
      fwd_b_sel <= FWD_SEL_RF;
    end else if (!pipe_hold) begin
      mem_q <= ex_q;
`ifdef FWD_RETIRE_BYPASS_EN
      wb_q  <= mem_q;
`endif
      if (issue) begin
        ex_q      <= id_entry;
        fwd_a_sel <= sel_a;
        fwd_b_sel <= sel_b;
      end else begin
        ex_q      <= '0;
        fwd_a_sel <= FWD_SEL_RF;
        fwd_b_sel <= FWD_SEL_RF;
      end
    end
  end

endmodule
